inst_decode_queue: RTL and testbench
====================================

Name: inst_decode_queue

Overview:
- Buffered, parametrised decode stage between fetch and issue.
- Accepts raw 32-bit instructions plus PC over a val/rdy handshake and holds them in a DEPTH-entry FIFO.
- Presents the decoded head entry (uop, register addresses, immediate select, operand/jump selects) to issue over a second val/rdy handshake.
- Supports squash on redirect, illegal-instruction flagging instead of dropping, optional M and full-branch decode, and suppression of x0 writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- EN_MUL, 1, decode MUL when 1; otherwise MUL is illegal.
- EN_BR_ALL, 1, decode BEQ/BLT/BGE/BLTU/BGEU when 1; BNE is always decoded.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- squash  in  1  flush all buffered entries this cycle
- in_val  in  1  fetch entry valid
- in_rdy  out  1  queue can accept
- in_inst  in  32  raw instruction
- in_pc  in  32  instruction PC
- out_val  out  1  head entry valid
- out_rdy  in  1  issue accepts head
- out_pc  out  32  head PC
- out_illegal  out  1  head did not decode
- out_uop  out  rv_uop  micro-op (UArch enum)
- out_raddr0, out_raddr1  out  5  source registers; 0 when unused
- out_waddr  out  5  destination register
- out_wen  out  1  register write enable
- out_imm_sel  out  rv_imm_type  immediate format
- out_op2_sel  out  1  1 = immediate, 0 = register file
- out_jal  out  2  0 = none, 1 = JAL, 2 = JALR
- out_op3_sel  out  1  0 = memory, 1 = branch
- occupancy  out  $clog2(DEPTH)+1  entries held

Behaviour:
- Reset (async, rst_n=0): all entries invalid; head and tail pointers 0; occupancy=0; out_val=0; in_rdy=1.
- Reset outputs: out_* data fields are 0, except out_illegal=0 while out_val=0.
- Storage: FIFO holds raw {inst, pc}.
- Decode is combinational on the head entry, so the minimum in-to-out latency is 1 cycle. There is no same-cycle bypass.
- Enqueue when in_val && in_rdy. in_rdy = (occupancy != DEPTH), with no dependence on out_rdy. Full plus a simultaneous dequeue still rejects input that cycle.
- Dequeue when out_val && out_rdy. out_val = (occupancy != 0).
- Simultaneous enqueue and dequeue when not full: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- squash=1: at the clock edge, occupancy, head and tail are cleared.
  - An enqueue in the same cycle is dropped.
  - Squash dominates enqueue and dequeue.
  - out_val is unaffected within the squash cycle itself.
- Decoded set:
  - Always: ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, ADDI, ANDI, ORI, XORI, SLTI, SLTIU, LUI, AUIPC, LW, SW, JAL, JALR, BNE.
  - MUL when EN_MUL=1.
  - BEQ, BLT, BGE, BLTU, BGEU when EN_BR_ALL=1.
  - Matching uses full opcode/funct3/funct7; any non-matching bits make the instruction illegal.
  - rv_uop gains matching OP_* values; rv_imm_type gains IMM_U.
- Field rules:
  - R-type: raddr0=rs1, raddr1=rs2, op2_sel=0.
  - I-type ALU, LW, JALR: raddr0=rs1, raddr1=0, imm I, op2_sel=1.
  - SW: raddr0=rs1, raddr1=rs2, imm S, wen=0, waddr=0, op3_sel=0.
  - Branches: raddr0=rs1, raddr1=rs2, imm B, wen=0, op2_sel=0, op3_sel=1.
  - LUI/AUIPC: raddr0=0, raddr1=0, imm U. JAL: raddr0=0, raddr1=0, imm J, jal=1.
  - LW: op3_sel=0. Don't-care op3_sel drives 0.
  - x0 writes: out_wen = decoded_wen && (rd != 0); out_waddr=rd regardless.
- Illegal head: out_val=1, out_illegal=1, wen=0, jal=0, raddr0=0, raddr1=0, waddr=0, uop=OP_ADD. The entry dequeues normally.
- All out_* fields are stable while out_val && !out_rdy.

Test Plan:
- Reset then in 0x002081B3 (ADD x3,x1,x2) at cycle 0 -> cycle 1: out_val=1, uop=OP_ADD, raddr0=1, raddr1=2, waddr=3, wen=1, op2_sel=0, occupancy=1.
- 0x00000013 (ADDI x0,x0,0) -> uop=OP_ADD, imm_sel=IMM_I, op2_sel=1, waddr=0, wen=0.
- 0x022081B3 (MUL) with EN_MUL=0 -> out_illegal=1, wen=0. With EN_MUL=1 -> uop=OP_MUL, illegal=0.
- 0x00208463 (BEQ x1,x2,+8), EN_BR_ALL=1 -> uop=OP_BEQ, imm_sel=IMM_B, op3_sel=1, wen=0, raddr1=2.
- DEPTH=4, out_rdy=0, push 5 instructions -> in_rdy=0 after 4, occupancy=4. Then out_rdy=1 with in_val=1 -> outputs drain in order and the 5th is accepted once occupancy<4.
- Occupancy 3, assert squash with in_val=1 -> next cycle occupancy=0, out_val=0, squashed input never appears. Async rst_n low mid-stream -> immediate out_val=0, occupancy=0.

Source files
------------

// File: rtl/inst_decode_queue.sv
// -----------------------------------------------------------------------------
// inst_decode_queue
//
// Decode stage between fetch and issue. Raw {inst, pc} pairs are buffered in a
// DEPTH-entry FIFO. The head entry is decoded combinationally and presented to
// issue. Both sides use a val/rdy handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   squash              flush every buffered entry at the next clock edge
//   in_val/in_rdy       fetch handshake; in_inst/in_pc carry the raw entry
//   out_val/out_rdy     issue handshake for the decoded head entry
//   out_pc              PC of the head entry
//   out_illegal         head entry did not match any enabled instruction
//   out_uop             micro-op
//   out_raddr0/1        source registers (0 when unused)
//   out_waddr/out_wen   destination register and write enable (x0 suppressed)
//   out_imm_sel         immediate format
//   out_op2_sel         1 = immediate, 0 = register file
//   out_jal             0 = none, 1 = JAL, 2 = JALR
//   out_op3_sel         0 = memory, 1 = branch
//   occupancy           number of entries held
// -----------------------------------------------------------------------------
package inst_decode_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,
    OP_SUB   = 5'd1,
    OP_AND   = 5'd2,
    OP_OR    = 5'd3,
    OP_XOR   = 5'd4,
    OP_SLT   = 5'd5,
    OP_SLTU  = 5'd6,
    OP_SLL   = 5'd7,
    OP_SRL   = 5'd8,
    OP_SRA   = 5'd9,
    OP_MUL   = 5'd10,
    OP_LUI   = 5'd11,
    OP_AUIPC = 5'd12,
    OP_LW    = 5'd13,
    OP_SW    = 5'd14,
    OP_JAL   = 5'd15,
    OP_JALR  = 5'd16,
    OP_BEQ   = 5'd17,
    OP_BNE   = 5'd18,
    OP_BLT   = 5'd19,
    OP_BGE   = 5'd20,
    OP_BLTU  = 5'd21,
    OP_BGEU  = 5'd22
  } rv_uop;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } rv_imm_type;

endpackage

module inst_decode_queue
  import inst_decode_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int EN_MUL    = 1,
  parameter int EN_BR_ALL = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     squash,
  input  logic                     in_val,
  output logic                     in_rdy,
  input  logic [31:0]              in_inst,
  input  logic [31:0]              in_pc,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [31:0]              out_pc,
  output logic                     out_illegal,
  output rv_uop                    out_uop,
  output logic [4:0]               out_raddr0,
  output logic [4:0]               out_raddr1,
  output logic [4:0]               out_waddr,
  output logic                     out_wen,
  output rv_imm_type               out_imm_sel,
  output logic                     out_op2_sel,
  output logic [1:0]               out_jal,
  output logic                     out_op3_sel,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ---------------------------------------------------------------------------
  // FIFO control
  // ---------------------------------------------------------------------------
  logic [AW-1:0] head_reg, head_next;
  logic [AW-1:0] tail_reg, tail_next;
  logic [OW-1:0] occ_reg,  occ_next;
  logic          do_enq, do_deq;

  logic [63:0]   mem [DEPTH];

  assign in_rdy  = (occ_reg != OW'(DEPTH));
  assign out_val = (occ_reg != '0);
  assign do_enq  = in_val && in_rdy && !squash;
  assign do_deq  = out_val && out_rdy && !squash;
  assign occupancy = occ_reg;

  always_comb begin
    head_next = head_reg;
    tail_next = tail_reg;
    occ_next  = occ_reg;
    if (squash) begin
      head_next = '0;
      tail_next = '0;
      occ_next  = '0;
    end else begin
      if (do_enq) tail_next = tail_reg + AW'(1);
      if (do_deq) head_next = head_reg + AW'(1);
      case ({do_enq, do_deq})
        2'b10:   occ_next = occ_reg + OW'(1);
        2'b01:   occ_next = occ_reg - OW'(1);
        default: occ_next = occ_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
      occ_reg  <= occ_next;
    end
  end

  // Entry storage needs no reset: every output is gated by out_val.
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail_reg] <= {in_inst, in_pc};
  end

  // ---------------------------------------------------------------------------
  // Decode of the head entry
  // ---------------------------------------------------------------------------
  logic [63:0] head_word;
  logic [31:0] inst;
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;

  assign head_word = mem[head_reg];
  assign inst      = head_word[63:32];
  assign opcode    = inst[6:0];
  assign rd        = inst[11:7];
  assign f3        = inst[14:12];
  assign rs1       = inst[19:15];
  assign rs2       = inst[24:20];
  assign f7        = inst[31:25];

  logic       dec_illegal, dec_wen, dec_op2, dec_op3;
  rv_uop      dec_uop;
  rv_imm_type dec_imm;
  logic [4:0] dec_r0, dec_r1;
  logic [1:0] dec_jal;

  always_comb begin
    dec_illegal = 1'b0;
    dec_uop     = OP_ADD;
    dec_r0      = 5'd0;
    dec_r1      = 5'd0;
    dec_wen     = 1'b0;
    dec_imm     = IMM_I;
    dec_op2     = 1'b0;
    dec_op3     = 1'b0;
    dec_jal     = 2'd0;
    case (opcode)
      OPC_OP: begin
        dec_r0  = rs1;
        dec_r1  = rs2;
        dec_wen = 1'b1;
        if (f7 == 7'b0000000) begin
          case (f3)
            3'b000:  dec_uop = OP_ADD;
            3'b001:  dec_uop = OP_SLL;
            3'b010:  dec_uop = OP_SLT;
            3'b011:  dec_uop = OP_SLTU;
            3'b100:  dec_uop = OP_XOR;
            3'b101:  dec_uop = OP_SRL;
            3'b110:  dec_uop = OP_OR;
            default: dec_uop = OP_AND;
          endcase
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          dec_uop = OP_SUB;
        end else if (f7 == 7'b0100000 && f3 == 3'b101) begin
          dec_uop = OP_SRA;
        end else if (f7 == 7'b0000001 && f3 == 3'b000 && EN_MUL != 0) begin
          dec_uop = OP_MUL;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_r0  = rs1;
        dec_wen = 1'b1;
        dec_op2 = 1'b1;
        case (f3)
          3'b000:  dec_uop = OP_ADD;
          3'b010:  dec_uop = OP_SLT;
          3'b011:  dec_uop = OP_SLTU;
          3'b100:  dec_uop = OP_XOR;
          3'b110:  dec_uop = OP_OR;
          3'b111:  dec_uop = OP_AND;
          default: dec_illegal = 1'b1;  // immediate shifts are not decoded
        endcase
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_uop = (opcode == OPC_LUI) ? OP_LUI : OP_AUIPC;
        dec_wen = 1'b1;
        dec_imm = IMM_U;
        dec_op2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_uop     = OP_LW;
        dec_r0      = rs1;
        dec_wen     = 1'b1;
        dec_op2     = 1'b1;
        dec_illegal = (f3 != 3'b010);
      end
      OPC_STORE: begin
        dec_uop     = OP_SW;
        dec_r0      = rs1;
        dec_r1      = rs2;
        dec_imm     = IMM_S;
        dec_op2     = 1'b1;
        dec_illegal = (f3 != 3'b010);
      end
      OPC_JAL: begin
        dec_uop = OP_JAL;
        dec_wen = 1'b1;
        dec_imm = IMM_J;
        dec_op2 = 1'b1;
        dec_jal = 2'd1;
      end
      OPC_JALR: begin
        dec_uop     = OP_JALR;
        dec_r0      = rs1;
        dec_wen     = 1'b1;
        dec_op2     = 1'b1;
        dec_jal     = 2'd2;
        dec_illegal = (f3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec_r0  = rs1;
        dec_r1  = rs2;
        dec_imm = IMM_B;
        dec_op3 = 1'b1;
        case (f3)
          3'b001:  dec_uop = OP_BNE;
          3'b000:  dec_uop = OP_BEQ;
          3'b100:  dec_uop = OP_BLT;
          3'b101:  dec_uop = OP_BGE;
          3'b110:  dec_uop = OP_BLTU;
          3'b111:  dec_uop = OP_BGEU;
          default: dec_illegal = 1'b1;
        endcase
        // BNE is always present; the rest depend on the full-branch option.
        if (f3 != 3'b001 && EN_BR_ALL == 0) dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output gating: empty queue drives all zeros, illegal head drives the
  // harmless OP_ADD / no-write pattern while still flagging the entry.
  // ---------------------------------------------------------------------------
  logic head_legal;
  assign head_legal = out_val && !dec_illegal;

  assign out_pc      = out_val ? head_word[31:0] : 32'd0;
  assign out_illegal = out_val && dec_illegal;
  assign out_uop     = head_legal ? dec_uop : OP_ADD;
  assign out_raddr0  = head_legal ? dec_r0 : 5'd0;
  assign out_raddr1  = head_legal ? dec_r1 : 5'd0;
  // Instructions without a destination (stores, branches) report waddr 0;
  // x0 destinations keep rd but never write.
  assign out_waddr   = (head_legal && dec_wen) ? rd : 5'd0;
  assign out_wen     = head_legal && dec_wen && (rd != 5'd0);
  assign out_imm_sel = head_legal ? dec_imm : IMM_I;
  assign out_op2_sel = head_legal && dec_op2;
  assign out_jal     = head_legal ? dec_jal : 2'd0;
  assign out_op3_sel = head_legal && dec_op3;

endmodule

// File: tb/tb_inst_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_inst_decode_queue
//
// Directed bench for inst_decode_queue. Two instances share the same stimulus:
// dut (MUL and all branches enabled) and dut_min (both options disabled).
// -----------------------------------------------------------------------------
module tb_inst_decode_queue;
  import inst_decode_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        squash = 1'b0;
  logic        in_val = 1'b0;
  logic        out_rdy = 1'b0;
  logic [31:0] in_inst = 32'd0;
  logic [31:0] in_pc = 32'd0;

  logic        in_rdy, out_val, out_illegal, out_wen, out_op2_sel, out_op3_sel;
  logic [31:0] out_pc;
  rv_uop       out_uop;
  logic [4:0]  out_raddr0, out_raddr1, out_waddr;
  rv_imm_type  out_imm_sel;
  logic [1:0]  out_jal;
  logic [2:0]  occupancy;

  logic        m_in_rdy, m_out_val, m_out_illegal, m_out_wen, m_out_op2_sel, m_out_op3_sel;
  logic [31:0] m_out_pc;
  rv_uop       m_out_uop;
  logic [4:0]  m_out_raddr0, m_out_raddr1, m_out_waddr;
  rv_imm_type  m_out_imm_sel;
  logic [1:0]  m_out_jal;
  logic [2:0]  m_occupancy;

  inst_decode_queue #(.DEPTH(DEPTH), .EN_MUL(1), .EN_BR_ALL(1)) dut (
    .clk(clk), .rst_n(rst_n), .squash(squash),
    .in_val(in_val), .in_rdy(in_rdy), .in_inst(in_inst), .in_pc(in_pc),
    .out_val(out_val), .out_rdy(out_rdy), .out_pc(out_pc),
    .out_illegal(out_illegal), .out_uop(out_uop),
    .out_raddr0(out_raddr0), .out_raddr1(out_raddr1),
    .out_waddr(out_waddr), .out_wen(out_wen), .out_imm_sel(out_imm_sel),
    .out_op2_sel(out_op2_sel), .out_jal(out_jal), .out_op3_sel(out_op3_sel),
    .occupancy(occupancy)
  );

  inst_decode_queue #(.DEPTH(DEPTH), .EN_MUL(0), .EN_BR_ALL(0)) dut_min (
    .clk(clk), .rst_n(rst_n), .squash(squash),
    .in_val(in_val), .in_rdy(m_in_rdy), .in_inst(in_inst), .in_pc(in_pc),
    .out_val(m_out_val), .out_rdy(out_rdy), .out_pc(m_out_pc),
    .out_illegal(m_out_illegal), .out_uop(m_out_uop),
    .out_raddr0(m_out_raddr0), .out_raddr1(m_out_raddr1),
    .out_waddr(m_out_waddr), .out_wen(m_out_wen), .out_imm_sel(m_out_imm_sel),
    .out_op2_sel(m_out_op2_sel), .out_jal(m_out_jal), .out_op3_sel(m_out_op3_sel),
    .occupancy(m_occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Enqueue one entry while issue is stalled; returns just after the edge.
  task automatic enq(input logic [31:0] inst, input logic [31:0] pc);
    in_val  = 1'b1;
    in_inst = inst;
    in_pc   = pc;
    @(posedge clk);
    #1;
    in_val  = 1'b0;
  endtask

  task automatic deq();
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
  endtask

  logic [31:0] exp_pc [5];

  initial begin
    // ---------------- reset state ----------------
    #12;
    check("rst out_val",     32'(out_val), 32'd0);
    check("rst in_rdy",      32'(in_rdy), 32'd1);
    check("rst occupancy",   32'(occupancy), 32'd0);
    check("rst out_illegal", 32'(out_illegal), 32'd0);
    check("rst out_pc",      out_pc, 32'd0);
    check("rst out_wen",     32'(out_wen), 32'd0);
    rst_n = 1'b1;

    // ---------------- ADD x3,x1,x2 ----------------
    enq(32'h002081B3, 32'h0000_1000);
    @(negedge clk);
    check("add out_val",   32'(out_val), 32'd1);
    check("add uop",       32'(out_uop), 32'(OP_ADD));
    check("add raddr0",    32'(out_raddr0), 32'd1);
    check("add raddr1",    32'(out_raddr1), 32'd2);
    check("add waddr",     32'(out_waddr), 32'd3);
    check("add wen",       32'(out_wen), 32'd1);
    check("add op2_sel",   32'(out_op2_sel), 32'd0);
    check("add occupancy", 32'(occupancy), 32'd1);
    check("add pc",        out_pc, 32'h0000_1000);
    deq();
    check("add drained", 32'(occupancy), 32'd0);

    // ---------------- ADDI x0,x0,0 ----------------
    enq(32'h00000013, 32'h0000_1004);
    @(negedge clk);
    check("addi uop",     32'(out_uop), 32'(OP_ADD));
    check("addi imm_sel", 32'(out_imm_sel), 32'(IMM_I));
    check("addi op2_sel", 32'(out_op2_sel), 32'd1);
    check("addi waddr",   32'(out_waddr), 32'd0);
    check("addi wen",     32'(out_wen), 32'd0);
    deq();

    // ---------------- MUL x3,x1,x2 ----------------
    enq(32'h022081B3, 32'h0000_1008);
    @(negedge clk);
    check("mul uop",         32'(out_uop), 32'(OP_MUL));
    check("mul illegal",     32'(out_illegal), 32'd0);
    check("mul wen",         32'(out_wen), 32'd1);
    check("nomul val",       32'(m_out_val), 32'd1);
    check("nomul illegal",   32'(m_out_illegal), 32'd1);
    check("nomul wen",       32'(m_out_wen), 32'd0);
    check("nomul raddr0",    32'(m_out_raddr0), 32'd0);
    check("nomul waddr",     32'(m_out_waddr), 32'd0);
    check("nomul uop",       32'(m_out_uop), 32'(OP_ADD));
    deq();
    check("nomul dequeued",  32'(m_occupancy), 32'd0);

    // ---------------- BEQ x1,x2,+8 ----------------
    enq(32'h00208463, 32'h0000_100C);
    @(negedge clk);
    check("beq uop",       32'(out_uop), 32'(OP_BEQ));
    check("beq imm_sel",   32'(out_imm_sel), 32'(IMM_B));
    check("beq op3_sel",   32'(out_op3_sel), 32'd1);
    check("beq wen",       32'(out_wen), 32'd0);
    check("beq raddr0",    32'(out_raddr0), 32'd1);
    check("beq raddr1",    32'(out_raddr1), 32'd2);
    check("beq op2_sel",   32'(out_op2_sel), 32'd0);
    check("nobr beq ill",  32'(m_out_illegal), 32'd1);
    deq();

    // ---------------- BNE (decoded even without full branches) ----------------
    enq(32'h00209463, 32'h0000_1010);
    @(negedge clk);
    check("bne uop",       32'(out_uop), 32'(OP_BNE));
    check("nobr bne ill",  32'(m_out_illegal), 32'd0);
    check("nobr bne uop",  32'(m_out_uop), 32'(OP_BNE));
    deq();

    // ---------------- SW x2,4(x1) ----------------
    enq(32'h0020A223, 32'h0000_1014);
    @(negedge clk);
    check("sw uop",     32'(out_uop), 32'(OP_SW));
    check("sw imm_sel", 32'(out_imm_sel), 32'(IMM_S));
    check("sw wen",     32'(out_wen), 32'd0);
    check("sw waddr",   32'(out_waddr), 32'd0);
    check("sw raddr1",  32'(out_raddr1), 32'd2);
    check("sw op3_sel", 32'(out_op3_sel), 32'd0);
    deq();

    // ---------------- JAL x1,+8 ----------------
    enq(32'h008000EF, 32'h0000_1018);
    @(negedge clk);
    check("jal uop",     32'(out_uop), 32'(OP_JAL));
    check("jal jal",     32'(out_jal), 32'd1);
    check("jal imm_sel", 32'(out_imm_sel), 32'(IMM_J));
    check("jal waddr",   32'(out_waddr), 32'd1);
    check("jal raddr0",  32'(out_raddr0), 32'd0);
    deq();

    // ---------------- all-zero word is illegal ----------------
    enq(32'h00000000, 32'h0000_101C);
    @(negedge clk);
    check("zero illegal", 32'(out_illegal), 32'd1);
    check("zero out_val", 32'(out_val), 32'd1);
    check("zero pc",      out_pc, 32'h0000_101C);
    deq();
    check("zero dequeued", 32'(occupancy), 32'd0);

    // ---------------- fill, overflow, drain in order ----------------
    exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h108;
    exp_pc[3] = 32'h10C; exp_pc[4] = 32'h110;
    for (int i = 0; i < 4; i++) enq(32'h002081B3, exp_pc[i]);
    @(negedge clk);
    check("full occupancy", 32'(occupancy), 32'd4);
    check("full in_rdy",    32'(in_rdy), 32'd0);
    in_val  = 1'b1;
    in_inst = 32'h002081B3;
    in_pc   = exp_pc[4];
    @(posedge clk);
    #1;
    check("full rejects", 32'(occupancy), 32'd4);
    check("stall pc",     out_pc, exp_pc[0]);
    out_rdy = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("drain pc%0d", k), out_pc, exp_pc[k]);
      @(posedge clk);
      #1;
      if (k == 1) in_val = 1'b0;
      if (k == 0) check("full+deq rejects", 32'(occupancy), 32'd3);
      if (k == 1) check("enq+deq occupancy", 32'(occupancy), 32'd3);
    end
    out_rdy = 1'b0;
    @(negedge clk);
    check("drained out_val", 32'(out_val), 32'd0);
    check("drained occupancy", 32'(occupancy), 32'd0);

    // ---------------- squash ----------------
    for (int i = 0; i < 3; i++) enq(32'h00000013, 32'h200 + 32'(i));
    @(negedge clk);
    check("pre-squash occupancy", 32'(occupancy), 32'd3);
    squash  = 1'b1;
    in_val  = 1'b1;
    in_inst = 32'h002081B3;
    in_pc   = 32'hDEAD_0000;
    #1;
    check("squash cycle out_val", 32'(out_val), 32'd1);
    @(posedge clk);
    #1;
    squash = 1'b0;
    in_val = 1'b0;
    @(negedge clk);
    check("post-squash occupancy", 32'(occupancy), 32'd0);
    check("post-squash out_val",   32'(out_val), 32'd0);
    enq(32'h00000013, 32'h0000_0300);
    @(negedge clk);
    check("post-squash head pc", out_pc, 32'h0000_0300);
    check("post-squash count",   32'(occupancy), 32'd1);
    deq();

    // ---------------- asynchronous reset mid-stream ----------------
    enq(32'h002081B3, 32'h400);
    enq(32'h002081B3, 32'h404);
    @(negedge clk);
    check("pre-reset occupancy", 32'(occupancy), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst out_val",   32'(out_val), 32'd0);
    check("async rst occupancy", 32'(occupancy), 32'd0);
    check("async rst in_rdy",    32'(in_rdy), 32'd1);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("after rst out_val", 32'(out_val), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
